rat_alu: RTL and testbench
==========================

Name: rat_alu

Overview:
- Parametrised successor to the fixed-function rational add/sub blocks: one unit performs ADD, SUB, MUL and DIV on signed fractions (num/den pairs).
- Uses a single shared signed multiplier, time-multiplexed over a small FSM.
- Valid/ready handshake on both sides; sign-normalised results; divide-by-zero and overflow flags.
- Sits in the rational datapath wherever add/sub were instantiated separately; no gcd reduction (done downstream).

Parameters:
- WIDTH, 32, bit width of each signed numerator/denominator, inputs and outputs.
- CHECK_OVF, 1, when 1 the ovf flag is computed; when 0, ovf is tied 0.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand/op presented.
- in_ready  out  1  unit can accept; high only in IDLE.
- op  in  2  00 ADD, 01 SUB, 10 MUL, 11 DIV.
- l_num, l_den, r_num, r_den  in  WIDTH each  signed two's-complement operands.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  downstream accepts.
- s_num, s_den  out  WIDTH each  signed result.
- div_zero  out  1  result denominator was zero.
- ovf  out  1  result not representable in signed WIDTH.

Behaviour:
- Reset: while rst is high and the cycle after, state=IDLE. in_ready=0 during rst, 1 after. out_valid=0; s_num, s_den, div_zero and ovf=0. rst mid-operation aborts; the in-flight result is discarded.
- Accept: in_valid && in_ready at an edge latches op and the four operands, then moves to P0. Inputs are don't-care after that.
- States: IDLE -> P0 -> P1 -> (P2 if ADD/SUB) -> NORM -> OUT -> IDLE.
- Products: one signed WIDTHxWIDTH -> 2*WIDTH product per P state, each registered.
  - ADD/SUB: P0 = l_num*r_den, P1 = l_den*r_num, P2 = l_den*r_den.
  - MUL: P0 = l_num*r_num, P1 = l_den*r_den.
  - DIV: P0 = l_num*r_den, P1 = l_den*r_num (P1 is the denominator).
- NORM:
  - Numerator: ADD = P0+P1, SUB = P0-P1, MUL/DIV = P0, computed in 2*WIDTH+1 bits. Denominator = P2 (ADD/SUB) or P1 (MUL/DIV).
  - If the denominator is negative, negate both numerator and denominator at full width.
  - If the denominator is 0: div_zero=1, s_num=0, s_den=0, ovf=0.
  - Otherwise s_num and s_den are the low WIDTH bits. ovf=1 if either full-width value lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- OUT: out_valid=1. Outputs and flags stay stable until out_valid && out_ready, then return to IDLE and out_valid drops.
- Latency, accept edge to out_valid high: ADD/SUB 5 cycles, MUL/DIV 4 cycles. Minimum interval between accepts is latency+1 cycles (in_ready is low outside IDLE).
- in_valid while busy is ignored; no queuing.
- Flags are valid only with out_valid.

Decomposition:
- Shared package rat_pkg: op encodings RAT_ADD/RAT_SUB/RAT_MUL/RAT_DIV, FSM state enum, default WIDTH constant.
- Sub-module rat_smul: combinational signed WIDTHxWIDTH -> 2*WIDTH multiplier. It is the single shared multiplier instance, so it can be swapped later for a pipelined version.

Test Plan:
1. WIDTH=32, ADD 1/2 + 1/3 -> s_num=5, s_den=6, flags 0; out_valid exactly 5 cycles after the accept edge.
2. SUB 1/2 - 3/4 -> s_num=-2, s_den=8 (unreduced); latency 5.
3. MUL 3/-4 * 2/5 -> raw 6/-20 normalised to s_num=-6, s_den=20; latency 4.
4. DIV 1/2 / 0/7 -> div_zero=1, s_num=0, s_den=0, ovf=0. Also ADD 1/0 + 1/2 -> div_zero=1.
5. WIDTH=8, MUL 100/1 * 100/1 -> ovf=1, s_num=0x10, s_den=1.
6. Backpressure and reset: ADD 1/2+1/3 with out_ready=0 for 10 cycles -> outputs stable, in_ready=0 throughout. Release -> handshake, next cycle in_ready=1. Separately, assert rst in P1 -> out_valid never rises for that op, outputs 0, and in_ready=1 the cycle after rst drops.

Source files
------------

// File: rtl/rat_pkg.sv
// Shared definitions for the rational ALU: op encodings, FSM states and
// the default operand width.
package rat_pkg;

   localparam int RAT_WIDTH = 32;

   typedef enum logic [1:0] {
      RAT_ADD = 2'b00,
      RAT_SUB = 2'b01,
      RAT_MUL = 2'b10,
      RAT_DIV = 2'b11
   } rat_op_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_P0   = 3'd1,
      ST_P1   = 3'd2,
      ST_P2   = 3'd3,
      ST_NORM = 3'd4,
      ST_OUT  = 3'd5
   } rat_state_e;

endpackage

// File: rtl/rat_smul.sv
// Combinational signed WIDTH x WIDTH -> 2*WIDTH multiplier. Kept as its own
// module so the single shared instance can later become a pipelined unit.
module rat_smul #(
   parameter int WIDTH = 32
) (
   input  logic signed [WIDTH-1:0]   a,
   input  logic signed [WIDTH-1:0]   b,
   output logic signed [2*WIDTH-1:0] p
);

   // Both operands are signed, so the product is sign-extended to 2*WIDTH.
   assign p = a * b;

endmodule

// File: rtl/rat_alu.sv
// Rational ALU: ADD/SUB/MUL/DIV on signed num/den pairs using one shared
// multiplier sequenced by a small FSM. Results are sign-normalised (positive
// denominator) but not gcd-reduced.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is high only in IDLE and never during rst; out_valid,
// s_num, s_den, div_zero and ovf are held stable from OUT until accepted.
module rat_alu
   import rat_pkg::*;
#(
   parameter int WIDTH     = RAT_WIDTH,
   parameter bit CHECK_OVF = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] l_num,
   input  logic [WIDTH-1:0] l_den,
   input  logic [WIDTH-1:0] r_num,
   input  logic [WIDTH-1:0] r_den,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s_num,
   output logic [WIDTH-1:0] s_den,
   output logic             div_zero,
   output logic             ovf,
   output rat_state_e       state_dbg
);

   localparam int PW = 2 * WIDTH;     // product width
   localparam int EW = 2 * WIDTH + 1; // normalisation width (sum/diff headroom)

   rat_state_e       state;
   rat_op_e          op_q;
   logic [WIDTH-1:0] l_num_q, l_den_q, r_num_q, r_den_q;
   logic [PW-1:0]    p0_q, p1_q, p2_q;

   logic [WIDTH-1:0] mul_a, mul_b;
   logic [PW-1:0]    prod;

   logic             is_addsub;
   logic [EW-1:0]    num_raw, den_raw, num_n, den_n;
   logic             den_zero, num_fit, den_fit;

   assign is_addsub = (op_q == RAT_ADD) || (op_q == RAT_SUB);
   assign in_ready  = (state == ST_IDLE) && !rst;
   assign state_dbg = state;

   // Select the multiplier operands for the product formed in this P state.
   always_comb begin
      mul_a = l_num_q;
      mul_b = r_den_q;
      case (state)
         ST_P0: begin
            mul_a = l_num_q;
            mul_b = (op_q == RAT_MUL) ? r_num_q : r_den_q;
         end
         ST_P1: begin
            mul_a = l_den_q;
            mul_b = (op_q == RAT_MUL) ? r_den_q : r_num_q;
         end
         ST_P2: begin
            mul_a = l_den_q;
            mul_b = r_den_q;
         end
         default: begin
            mul_a = l_num_q;
            mul_b = r_den_q;
         end
      endcase
   end

   rat_smul #(.WIDTH(WIDTH)) u_smul (
      .a (mul_a),
      .b (mul_b),
      .p (prod)
   );

   // Form the full-width numerator/denominator, move the sign onto the
   // numerator, and check both fit in signed WIDTH.
   always_comb begin
      num_raw = {p0_q[PW-1], p0_q};
      case (op_q)
         RAT_ADD: num_raw = {p0_q[PW-1], p0_q} + {p1_q[PW-1], p1_q};
         RAT_SUB: num_raw = {p0_q[PW-1], p0_q} - {p1_q[PW-1], p1_q};
         default: num_raw = {p0_q[PW-1], p0_q};
      endcase
      den_raw = is_addsub ? {p2_q[PW-1], p2_q} : {p1_q[PW-1], p1_q};
      if (den_raw[EW-1]) begin
         num_n = -num_raw;
         den_n = -den_raw;
      end else begin
         num_n = num_raw;
         den_n = den_raw;
      end
      den_zero = (den_raw == '0);
      // A value fits when every bit from the WIDTH sign position up matches.
      num_fit  = (num_n[EW-1:WIDTH-1] == '0) || (num_n[EW-1:WIDTH-1] == '1);
      den_fit  = (den_n[EW-1:WIDTH-1] == '0) || (den_n[EW-1:WIDTH-1] == '1);
   end

   // Sequencer: latch operands, form one product per P state, normalise,
   // then hold the result until downstream accepts it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         op_q      <= RAT_ADD;
         l_num_q   <= '0;
         l_den_q   <= '0;
         r_num_q   <= '0;
         r_den_q   <= '0;
         p0_q      <= '0;
         p1_q      <= '0;
         p2_q      <= '0;
         out_valid <= 1'b0;
         s_num     <= '0;
         s_den     <= '0;
         div_zero  <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  op_q    <= rat_op_e'(op);
                  l_num_q <= l_num;
                  l_den_q <= l_den;
                  r_num_q <= r_num;
                  r_den_q <= r_den;
                  state   <= ST_P0;
               end
            end
            ST_P0: begin
               p0_q  <= prod;
               state <= ST_P1;
            end
            ST_P1: begin
               p1_q  <= prod;
               state <= is_addsub ? ST_P2 : ST_NORM;
            end
            ST_P2: begin
               p2_q  <= prod;
               state <= ST_NORM;
            end
            ST_NORM: begin
               if (den_zero) begin
                  s_num    <= '0;
                  s_den    <= '0;
                  div_zero <= 1'b1;
                  ovf      <= 1'b0;
               end else begin
                  s_num    <= num_n[WIDTH-1:0];
                  s_den    <= den_n[WIDTH-1:0];
                  div_zero <= 1'b0;
                  ovf      <= CHECK_OVF && !(num_fit && den_fit);
               end
               out_valid <= 1'b1;
               state     <= ST_OUT;
            end
            ST_OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rat_alu.sv
// Directed bench for rat_alu: a 32-bit and an 8-bit instance share clock and
// reset; each scenario task drives vectors and compares against hand values.
module tb_rat_alu;
   import rat_pkg::*;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] ln, ld, rn, rd;
      logic [31:0] en, ed;
      logic        dz, ov;
      int          lat;
   } vec32_t;

   typedef struct {
      logic [1:0] op;
      logic [7:0] ln, ld, rn, rd;
      logic [7:0] en, ed;
      logic       dz, ov;
      int         lat;
   } vec8_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b1;
   logic [1:0]  a_op = 2'b00;
   logic [31:0] a_l_num = '0, a_l_den = '0, a_r_num = '0, a_r_den = '0;
   logic [31:0] a_s_num, a_s_den;
   logic        a_div_zero, a_ovf;
   rat_state_e  a_state;

   logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1;
   logic [1:0]  b_op = 2'b00;
   logic [7:0]  b_l_num = '0, b_l_den = '0, b_r_num = '0, b_r_den = '0;
   logic [7:0]  b_s_num, b_s_den;
   logic        b_div_zero, b_ovf;
   rat_state_e  b_state;

   int compared   = 0;
   int mismatched = 0;

   // Clock and reset
   always #5 clk = ~clk;

   rat_alu #(.WIDTH(32), .CHECK_OVF(1'b1)) dut32 (
      .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .op(a_op), .l_num(a_l_num), .l_den(a_l_den), .r_num(a_r_num), .r_den(a_r_den),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .s_num(a_s_num), .s_den(a_s_den),
      .div_zero(a_div_zero), .ovf(a_ovf), .state_dbg(a_state)
   );

   rat_alu #(.WIDTH(8), .CHECK_OVF(1'b1)) dut8 (
      .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .op(b_op), .l_num(b_l_num), .l_den(b_l_den), .r_num(b_r_num), .r_den(b_r_den),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .s_num(b_s_num), .s_den(b_s_den),
      .div_zero(b_div_zero), .ovf(b_ovf), .state_dbg(b_state)
   );

   // Driver: present one op, return the cycle on which out_valid is first
   // seen (cycle 1 = just after the accept edge), or 0 if it never rises.
   task automatic do_op32(input logic [1:0] op, input logic [31:0] ln, ld, rn, rd,
                          output int lat);
      @(negedge clk);
      a_op = op; a_l_num = ln; a_l_den = ld; a_r_num = rn; a_r_den = rd;
      a_in_valid = 1'b1;
      @(posedge clk);
      #1 a_in_valid = 1'b0;
      lat = 1;
      while (!a_out_valid && lat < 20) begin
         @(posedge clk);
         #1 lat++;
      end
      if (!a_out_valid) lat = 0;
   endtask

   task automatic do_op8(input logic [1:0] op, input logic [7:0] ln, ld, rn, rd,
                         output int lat);
      @(negedge clk);
      b_op = op; b_l_num = ln; b_l_den = ld; b_r_num = rn; b_r_den = rd;
      b_in_valid = 1'b1;
      @(posedge clk);
      #1 b_in_valid = 1'b0;
      lat = 1;
      while (!b_out_valid && lat < 20) begin
         @(posedge clk);
         #1 lat++;
      end
      if (!b_out_valid) lat = 0;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      compared++; if (a_in_ready !== 1'b0) begin mismatched++; $display("FAIL reset_in_ready got %b expected 0", a_in_ready); end
      compared++; if (a_out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid got %b expected 0", a_out_valid); end
      compared++; if (a_s_num !== 32'd0 || a_s_den !== 32'd0) begin mismatched++; $display("FAIL reset_result got %0h/%0h expected 0/0", a_s_num, a_s_den); end
      compared++; if (a_div_zero !== 1'b0 || a_ovf !== 1'b0) begin mismatched++; $display("FAIL reset_flags got dz=%b ovf=%b expected 0 0", a_div_zero, a_ovf); end
      compared++; if (b_out_valid !== 1'b0 || b_in_ready !== 1'b0) begin mismatched++; $display("FAIL reset_w8 got ov=%b ir=%b expected 0 0", b_out_valid, b_in_ready); end
      @(negedge clk) rst = 1'b0;
      #1;
      compared++; if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_release_ready got %b %b expected 1 1", a_in_ready, b_in_ready); end
      compared++; if (a_state !== ST_IDLE) begin mismatched++; $display("FAIL reset_state got %0d expected %0d", a_state, ST_IDLE); end
   endtask

   // 32-bit vectors: add/sub/mul/div plus sign normalisation and 32-bit ovf.
   task automatic test_arith32();
      vec32_t v[6];
      int lat;
      v[0] = '{RAT_ADD, 32'd1, 32'd2, 32'd1, 32'd3, 32'd5, 32'd6, 1'b0, 1'b0, 5};
      v[1] = '{RAT_SUB, 32'd1, 32'd2, 32'd3, 32'd4, -32'sd2, 32'd8, 1'b0, 1'b0, 5};
      v[2] = '{RAT_MUL, 32'd3, -32'sd4, 32'd2, 32'd5, -32'sd6, 32'd20, 1'b0, 1'b0, 4};
      v[3] = '{RAT_DIV, 32'd3, 32'd4, -32'sd5, 32'd7, -32'sd21, 32'd20, 1'b0, 1'b0, 4};
      v[4] = '{RAT_MUL, 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd1, 32'd0, 32'd1, 1'b0, 1'b1, 4};
      v[5] = '{RAT_DIV, 32'd1, 32'h8000_0000, 32'd1, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1, 4};
      a_out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         do_op32(v[i].op, v[i].ln, v[i].ld, v[i].rn, v[i].rd, lat);
         compared++; if (lat !== v[i].lat) begin mismatched++; $display("FAIL arith32[%0d] latency got %0d expected %0d", i, lat, v[i].lat); end
         compared++; if (a_s_num !== v[i].en) begin mismatched++; $display("FAIL arith32[%0d] s_num got %0h expected %0h", i, a_s_num, v[i].en); end
         compared++; if (a_s_den !== v[i].ed) begin mismatched++; $display("FAIL arith32[%0d] s_den got %0h expected %0h", i, a_s_den, v[i].ed); end
         compared++; if (a_div_zero !== v[i].dz || a_ovf !== v[i].ov) begin mismatched++; $display("FAIL arith32[%0d] flags got dz=%b ovf=%b expected dz=%b ovf=%b", i, a_div_zero, a_ovf, v[i].dz, v[i].ov); end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_div_zero();
      vec32_t v[2];
      int lat;
      v[0] = '{RAT_DIV, 32'd1, 32'd2, 32'd0, 32'd7, 32'd0, 32'd0, 1'b1, 1'b0, 4};
      v[1] = '{RAT_ADD, 32'd1, 32'd0, 32'd1, 32'd2, 32'd0, 32'd0, 1'b1, 1'b0, 5};
      a_out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         do_op32(v[i].op, v[i].ln, v[i].ld, v[i].rn, v[i].rd, lat);
         compared++; if (lat !== v[i].lat) begin mismatched++; $display("FAIL divzero[%0d] latency got %0d expected %0d", i, lat, v[i].lat); end
         compared++; if (a_div_zero !== 1'b1 || a_ovf !== 1'b0) begin mismatched++; $display("FAIL divzero[%0d] flags got dz=%b ovf=%b expected dz=1 ovf=0", i, a_div_zero, a_ovf); end
         compared++; if (a_s_num !== 32'd0 || a_s_den !== 32'd0) begin mismatched++; $display("FAIL divzero[%0d] result got %0h/%0h expected 0/0", i, a_s_num, a_s_den); end
         @(posedge clk);
         #1;
      end
   endtask

   // 8-bit instance: overflow boundaries at +127 / -128 / +128.
   task automatic test_ovf8();
      vec8_t v[5];
      int lat;
      v[0] = '{RAT_MUL, 8'd100, 8'd1, 8'd100, 8'd1, 8'h10, 8'd1, 1'b0, 1'b1, 4};
      v[1] = '{RAT_MUL, 8'd127, 8'd1, 8'd1, 8'd1, 8'd127, 8'd1, 1'b0, 1'b0, 4};
      v[2] = '{RAT_MUL, 8'h80, 8'd1, 8'd1, 8'd1, 8'h80, 8'd1, 1'b0, 1'b0, 4};
      v[3] = '{RAT_MUL, 8'h80, 8'd1, 8'hFF, 8'd1, 8'h80, 8'd1, 1'b0, 1'b1, 4};
      v[4] = '{RAT_ADD, 8'd1, 8'd2, 8'd1, 8'd3, 8'd5, 8'd6, 1'b0, 1'b0, 5};
      b_out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         do_op8(v[i].op, v[i].ln, v[i].ld, v[i].rn, v[i].rd, lat);
         compared++; if (lat !== v[i].lat) begin mismatched++; $display("FAIL ovf8[%0d] latency got %0d expected %0d", i, lat, v[i].lat); end
         compared++; if (b_s_num !== v[i].en || b_s_den !== v[i].ed) begin mismatched++; $display("FAIL ovf8[%0d] result got %0h/%0h expected %0h/%0h", i, b_s_num, b_s_den, v[i].en, v[i].ed); end
         compared++; if (b_ovf !== v[i].ov || b_div_zero !== v[i].dz) begin mismatched++; $display("FAIL ovf8[%0d] flags got ovf=%b dz=%b expected ovf=%b dz=%b", i, b_ovf, b_div_zero, v[i].ov, v[i].dz); end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_backpressure();
      int lat;
      int bad;
      a_out_ready = 1'b0;
      do_op32(RAT_ADD, 32'd1, 32'd2, 32'd1, 32'd3, lat);
      compared++; if (lat !== 5) begin mismatched++; $display("FAIL bp_latency got %0d expected 5", lat); end
      // Hold off downstream while offering a different op that must be ignored.
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         a_op = RAT_MUL; a_l_num = 32'd7; a_l_den = 32'd1; a_r_num = 32'd7; a_r_den = 32'd1;
         a_in_valid = 1'b1;
         @(posedge clk);
         #1;
         if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 || a_s_num !== 32'd5 ||
             a_s_den !== 32'd6 || a_div_zero !== 1'b0 || a_ovf !== 1'b0) bad++;
      end
      compared++; if (bad != 0) begin mismatched++; $display("FAIL bp_hold got %0d unstable cycles expected 0", bad); end
      @(negedge clk);
      a_in_valid  = 1'b0;
      a_out_ready = 1'b1;
      @(posedge clk);
      #1;
      compared++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin mismatched++; $display("FAIL bp_release got ov=%b ir=%b expected 0 1", a_out_valid, a_in_ready); end
      bad = 0;
      for (int i = 0; i < 7; i++) begin
         @(posedge clk);
         #1 if (a_out_valid !== 1'b0) bad++;
      end
      compared++; if (bad != 0) begin mismatched++; $display("FAIL bp_no_queue got %0d valid cycles expected 0", bad); end
   endtask

   task automatic test_reset_mid_op();
      int bad;
      a_out_ready = 1'b1;
      @(negedge clk);
      a_op = RAT_ADD; a_l_num = 32'd1; a_l_den = 32'd2; a_r_num = 32'd1; a_r_den = 32'd3;
      a_in_valid = 1'b1;
      @(posedge clk);
      #1 a_in_valid = 1'b0;
      @(posedge clk);
      #1;
      compared++; if (a_state !== ST_P1) begin mismatched++; $display("FAIL midrst_state got %0d expected %0d", a_state, ST_P1); end
      rst = 1'b1;
      #1;
      compared++; if (a_in_ready !== 1'b0) begin mismatched++; $display("FAIL midrst_in_ready got %b expected 0", a_in_ready); end
      @(posedge clk);
      #1;
      compared++; if (a_out_valid !== 1'b0 || a_s_num !== 32'd0 || a_s_den !== 32'd0 || a_div_zero !== 1'b0 || a_ovf !== 1'b0) begin
         mismatched++; $display("FAIL midrst_outputs got ov=%b %0h/%0h dz=%b ovf=%b expected all 0", a_out_valid, a_s_num, a_s_den, a_div_zero, a_ovf);
      end
      @(negedge clk) rst = 1'b0;
      #1;
      compared++; if (a_in_ready !== 1'b1) begin mismatched++; $display("FAIL midrst_release got %b expected 1", a_in_ready); end
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1 if (a_out_valid !== 1'b0) bad++;
      end
      compared++; if (bad != 0) begin mismatched++; $display("FAIL midrst_no_result got %0d valid cycles expected 0", bad); end
   endtask

   initial begin
      test_reset();
      test_arith32();
      test_div_zero();
      test_ovf8();
      test_backpressure();
      test_reset_mid_op();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
